// File: rtl/axis_pkt_arbiter.sv
// Two-source AXI-Stream packet arbiter: round-robin per packet, no preemption,
// one IDLE cycle between packets, packet counter and sticky overlong flag.
module axis_pkt_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                s0_tvalid,
  output logic                s0_tready,
  input  logic [DATA_W-1:0]   s0_tdata,
  input  logic [DATA_W/8-1:0] s0_tkeep,
  input  logic                s0_tlast,
  input  logic                s1_tvalid,
  output logic                s1_tready,
  input  logic [DATA_W-1:0]   s1_tdata,
  input  logic [DATA_W/8-1:0] s1_tkeep,
  input  logic                s1_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic [1:0]          grant,
  output logic [15:0]         pkt_cnt,
  output logic                err_overlong
);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam logic [15:0] LAST_OK_BEAT = 16'(MAX_BEATS - 1);

  state_t      state_r, state_s;
  logic [1:0]  grant_r, grant_s;
  logic        last_src_r;   // 1'b1 means source 1 owned the previous packet
  logic [15:0] pkt_cnt_r;
  logic [15:0] beat_cnt_r;
  logic        err_r;
  logic        sel_s;
  logic        beat_s;
  logic        end_s;

  assign sel_s        = grant_r[1];
  assign beat_s       = m_tvalid & m_tready;
  assign end_s        = beat_s & m_tlast;
  assign grant        = grant_r;
  assign pkt_cnt      = pkt_cnt_r;
  assign err_overlong = err_r;

  // Route the granted source to the master port; everything idles low otherwise.
  always_comb begin
    m_tvalid  = 1'b0;
    m_tdata   = {DATA_W{1'b0}};
    m_tkeep   = {(DATA_W/8){1'b0}};
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    if (state_r == XFER) begin
      if (sel_s) begin
        m_tvalid  = s1_tvalid;
        m_tdata   = s1_tdata;
        m_tkeep   = s1_tkeep;
        m_tlast   = s1_tlast;
        s1_tready = m_tready;
      end else begin
        m_tvalid  = s0_tvalid;
        m_tdata   = s0_tdata;
        m_tkeep   = s0_tkeep;
        m_tlast   = s0_tlast;
        s0_tready = m_tready;
      end
    end else begin
      m_tvalid  = 1'b0;
      s0_tready = 1'b0;
      s1_tready = 1'b0;
    end
  end

  // Next state and next grant; contention goes to the source that did not own the last packet.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    case (state_r)
      IDLE: begin
        if (enable && (s0_tvalid || s1_tvalid)) begin
          state_s = XFER;
          if (s0_tvalid && s1_tvalid) begin
            grant_s = last_src_r ? 2'b01 : 2'b10;
          end else if (s0_tvalid) begin
            grant_s = 2'b01;
          end else begin
            grant_s = 2'b10;
          end
        end else begin
          state_s = IDLE;
          grant_s = 2'b00;
        end
      end
      XFER: begin
        if (end_s) begin
          state_s = IDLE;
          grant_s = 2'b00;
        end else begin
          state_s = XFER;
          grant_s = grant_r;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = 2'b00;
      end
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= 2'b00;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
    end
  end

  // Packet bookkeeping: owner history, packet count, beat count and overlong flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_src_r <= 1'b1;
      pkt_cnt_r  <= 16'd0;
      beat_cnt_r <= 16'd0;
      err_r      <= 1'b0;
    end else if (end_s) begin
      last_src_r <= sel_s;
      pkt_cnt_r  <= pkt_cnt_r + 16'd1;
      beat_cnt_r <= 16'd0;
    end else if (beat_s) begin
      beat_cnt_r <= beat_cnt_r + 16'd1;
      if (beat_cnt_r == LAST_OK_BEAT) begin
        err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: per-source beat queues feed the slaves,
// a scoreboard queue holds the expected master beats in arrival order.
module tb_axis_pkt_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic        s0_tvalid, s0_tready, s0_tlast;
  logic [31:0] s0_tdata;
  logic [3:0]  s0_tkeep;
  logic        s1_tvalid, s1_tready, s1_tlast;
  logic [31:0] s1_tdata;
  logic [3:0]  s1_tkeep;
  logic        m_tvalid, m_tready, m_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic [1:0]  grant;
  logic [15:0] pkt_cnt;
  logic        err_overlong;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          s0_rdy_cnt = 0;
  bit          mon_en = 1'b1;
  beat_t       src0_q[$];
  beat_t       src1_q[$];
  beat_t       last_pkt[$];
  logic [38:0] exp_q[$];
  logic [38:0] mon_e;
  int          last_cyc_q[$];
  logic        err_log[$];

  always #5 clk = ~clk;

  axis_pkt_arbiter #(.DATA_W(32), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .grant(grant), .pkt_cnt(pkt_cnt), .err_overlong(err_overlong)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int src, input int n, input bit to_exp);
    beat_t b;
    last_pkt.delete();
    for (int i = 0; i < n; i++) begin
      b.data = $urandom();
      b.keep = (i == n - 1) ? 4'($urandom_range(1, 15)) : 4'hF;
      b.last = (i == n - 1);
      last_pkt.push_back(b);
      if (src == 0) src0_q.push_back(b);
      else src1_q.push_back(b);
      if (to_exp) exp_q.push_back({(src == 0) ? 2'b01 : 2'b10, b});
    end
  endtask

  task automatic drain(input int left, input string tag);
    int n = 0;
    while (exp_q.size() > left && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size() <= left), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_shown(input logic [31:0] d, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(m_tvalid === 1'b1 && m_tdata === d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(m_tvalid === 1'b1 && m_tdata === d), 64'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Source 0 driver: retire a beat after a handshake, then present the queue head.
  initial begin
    bit f0;
    s0_tvalid = 1'b0; s0_tdata = 32'd0; s0_tkeep = 4'd0; s0_tlast = 1'b0;
    forever begin
      @(negedge clk);
      f0 = s0_tvalid && s0_tready;
      @(posedge clk);
      #1;
      if (f0 && src0_q.size() > 0) src0_q.delete(0);
      if (src0_q.size() > 0) begin
        s0_tvalid = 1'b1;
        {s0_tdata, s0_tkeep, s0_tlast} = src0_q[0];
      end else begin
        s0_tvalid = 1'b0;
      end
    end
  end

  // Source 1 driver.
  initial begin
    bit f1;
    s1_tvalid = 1'b0; s1_tdata = 32'd0; s1_tkeep = 4'd0; s1_tlast = 1'b0;
    forever begin
      @(negedge clk);
      f1 = s1_tvalid && s1_tready;
      @(posedge clk);
      #1;
      if (f1 && src1_q.size() > 0) src1_q.delete(0);
      if (src1_q.size() > 0) begin
        s1_tvalid = 1'b1;
        {s1_tdata, s1_tkeep, s1_tlast} = src1_q[0];
      end else begin
        s1_tvalid = 1'b0;
      end
    end
  end

  // Monitor: every master handshake is checked against the scoreboard head.
  always @(negedge clk) begin
    if (s0_tready === 1'b1) s0_rdy_cnt++;
    if (mon_en && rst === 1'b0 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat", 64'({grant, m_tdata, m_tkeep, m_tlast}), 64'(mon_e));
      end
      err_log.push_back(err_overlong);
      if (m_tlast) last_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cbase, ebase, rbase;
    logic [31:0] d1, d2, d3;
    rst = 1'b1; enable = 1'b0; m_tready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s0_tready", 64'(s0_tready), 64'd0);
    check("rst_s1_tready", 64'(s1_tready), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_err", 64'(err_overlong), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", 64'(grant), 64'd0);
    check("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);

    // Round robin, both sources continuous, 4-beat packets
    cbase = last_cyc_q.size();
    push_pkt(0, 4, 1'b1); push_pkt(1, 4, 1'b1); push_pkt(0, 4, 1'b1); push_pkt(1, 4, 1'b1);
    @(posedge clk); #1 enable = 1'b1; m_tready = 1'b1;
    drain(0, "rr_drain");
    check("rr_pkt_cnt", 64'(pkt_cnt), 64'd4);
    check("rr_last_count", 64'(last_cyc_q.size() - cbase), 64'd4);
    if (last_cyc_q.size() >= cbase + 4) begin
      for (int i = 1; i < 4; i++)
        check("rr_pkt_period", 64'(last_cyc_q[cbase + i] - last_cyc_q[cbase + i - 1]), 64'd5);
    end
    check("max_len_no_err", 64'(err_overlong), 64'd0);

    // Only source 1, single-beat packets, plus arbitration latency
    rbase = s0_rdy_cnt;
    push_pkt(1, 1, 1'b1); push_pkt(1, 1, 1'b1); push_pkt(1, 1, 1'b1);
    @(negedge clk);
    check("arb_lat_before", 64'(grant), 64'd0);
    @(negedge clk);
    check("arb_lat_after", 64'(grant), 64'd2);
    drain(0, "s1_only_drain");
    check("s1_only_pkt_cnt", 64'(pkt_cnt), 64'd7);
    check("s1_only_s0_tready", 64'(s0_rdy_cnt - rbase), 64'd0);

    // Overlong: 6-beat packet with MAX_BEATS=4
    ebase = err_log.size();
    push_pkt(0, 6, 1'b1);
    drain(0, "overlong_drain");
    if (err_log.size() >= ebase + 6) begin
      for (int i = 0; i < 6; i++)
        check("overlong_timing", 64'(err_log[ebase + i]), (i >= 4) ? 64'd1 : 64'd0);
    end else begin
      check("overlong_beats", 64'(err_log.size() - ebase), 64'd6);
    end
    check("overlong_sticky", 64'(err_overlong), 64'd1);
    check("overlong_pkt_cnt", 64'(pkt_cnt), 64'd8);

    // Mid-packet stall of 5 cycles on beat 2 of 8
    @(posedge clk); #1 m_tready = 1'b0;
    @(negedge clk);
    push_pkt(0, 8, 1'b1);
    d1 = last_pkt[0].data; d2 = last_pkt[1].data;
    wait_shown(d1, "stall_first_beat");
    @(posedge clk); #1 m_tready = 1'b1;
    @(posedge clk); #1 m_tready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 64'(m_tvalid), 64'd1);
      check("stall_data", 64'(m_tdata), 64'(d2));
      check("stall_s0_tready", 64'(s0_tready), 64'd0);
    end
    @(posedge clk); #1 m_tready = 1'b1;
    drain(0, "stall_drain");
    check("stall_pkt_cnt", 64'(pkt_cnt), 64'd9);

    // enable dropped on beat 3 of 6; both sources then wait
    push_pkt(0, 6, 1'b1);
    d3 = last_pkt[2].data;
    wait_shown(d3, "en_drop_beat3");
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    push_pkt(1, 1, 1'b1); push_pkt(0, 1, 1'b1);
    drain(2, "en_drop_drain");
    check("en_drop_pkt_cnt", 64'(pkt_cnt), 64'd10);
    repeat (4) begin
      @(negedge clk);
      check("en_low_grant", 64'(grant), 64'd0);
    end
    @(posedge clk); #1 enable = 1'b1;
    drain(0, "en_high_drain");
    check("en_high_pkt_cnt", 64'(pkt_cnt), 64'd12);
    check("err_still_set", 64'(err_overlong), 64'd1);

    // Reset on beat 2 abandons the packet
    @(posedge clk); #1 mon_en = 1'b0;
    @(negedge clk);
    push_pkt(1, 4, 1'b0);
    d1 = last_pkt[0].data;
    wait_shown(d1, "rst_mid_first_beat");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_grant", 64'(grant), 64'd0);
    check("rst_mid_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_mid_s0_tready", 64'(s0_tready), 64'd0);
    check("rst_mid_s1_tready", 64'(s1_tready), 64'd0);
    check("rst_mid_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_mid_err", 64'(err_overlong), 64'd0);
    src1_q.delete();
    @(posedge clk); #1 rst = 1'b0; mon_en = 1'b1;

    // Counter wrap; first contention after reset goes to source 0
    @(posedge clk); #1 force dut.pkt_cnt_r = 16'hFFFE;
    @(posedge clk); #1 release dut.pkt_cnt_r;
    @(negedge clk);
    check("preload_pkt_cnt", 64'(pkt_cnt), 64'hFFFE);
    push_pkt(0, 1, 1'b1); push_pkt(1, 1, 1'b1);
    drain(0, "wrap_drain");
    check("wrap_pkt_cnt", 64'(pkt_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
